// File: rtl/bs_pkg.sv
// Shared definitions for the bit-serial receiver: state encoding, default word
// length and the bit-counter sizing helper.
package bs_pkg;

  typedef enum logic {
    BS_IDLE  = 1'b0,
    BS_SHIFT = 1'b1
  } bs_state_t;

  localparam int BS_LEN = 22;

  // Counter must hold 0..len inclusive.
  function automatic int bs_cnt_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/bs_fifo2.sv
// Two-entry valid/ready buffer; head is always slot0 and every output is a
// flop. A push into a full buffer without a pop is ignored here.
module bs_fifo2 #(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         valid
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         occ0;
  logic         occ1;
  logic         take;

  assign take = pop && occ0;

  // Occupancy is one-hot-ish: occ0 = at least one entry, occ1 = two entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot0 <= '0;
      slot1 <= '0;
      occ0  <= 1'b0;
      occ1  <= 1'b0;
    end else begin
      case ({push, take})
        2'b10: begin
          if (!occ0) begin
            slot0 <= push_data;
            occ0  <= 1'b1;
          end else if (!occ1) begin
            slot1 <= push_data;
            occ1  <= 1'b1;
          end
        end
        2'b01: begin
          if (occ1) begin
            slot0 <= slot1;
            occ1  <= 1'b0;
          end else begin
            occ0  <= 1'b0;
          end
        end
        2'b11: begin
          if (occ1) begin
            slot0 <= slot1;
            slot1 <= push_data;
          end else begin
            slot0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = slot0;
  assign valid = occ0;
  assign full  = occ1;

endmodule

// File: rtl/bs_deser.sv
// Bit-serial LSB-first receiver: assembles LEN-bit words framed by isync and
// hands them to a 2-entry output buffer, with sticky framing/overrun flags.
module bs_deser
  import bs_pkg::*;
#(
  parameter int LEN = BS_LEN
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           is,
  input  logic           isync,
  output logic [LEN-1:0] o_data,
  output logic           o_valid,
  input  logic           o_ready,
  output logic           busy,
  output logic           frame_err,
  output logic           overrun,
  input  logic           clear_err
);

  localparam int CW = bs_cnt_w(LEN);

  bs_state_t      state;
  bs_state_t      state_n;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_n;
  logic [LEN-1:0] shift;
  logic [LEN-1:0] shift_n;
  logic           word_done;
  logic           ferr_set;
  logic           ovr_set;
  logic           fifo_push;
  logic           fifo_full;
  logic           fifo_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BS_IDLE;
      cnt   <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      shift <= shift_n;
    end
  end

  // An isync always restarts at bit 0, whether idle or mid-frame.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shift_n   = shift;
    word_done = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      BS_IDLE: begin
        if (isync) begin
          shift_n    = '0;
          shift_n[0] = is;
          cnt_n      = CW'(1);
          state_n    = BS_SHIFT;
        end
      end
      BS_SHIFT: begin
        if (isync) begin
          ferr_set   = 1'b1;
          shift_n    = '0;
          shift_n[0] = is;
          cnt_n      = CW'(1);
        end else begin
          shift_n[cnt] = is;
          if (cnt == CW'(LEN - 1)) begin
            word_done = 1'b1;
            cnt_n     = '0;
            state_n   = BS_IDLE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      default: state_n = BS_IDLE;
    endcase
  end

  // A full buffer can still accept a word if its head leaves this cycle.
  assign fifo_pop  = o_valid && o_ready;
  assign fifo_push = word_done && (!fifo_full || fifo_pop);
  assign ovr_set   = word_done && fifo_full && !fifo_pop;

  bs_fifo2 #(.W(LEN)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (shift_n),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .head      (o_data),
    .valid     (o_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (ferr_set)       frame_err <= 1'b1;
      else if (clear_err) frame_err <= 1'b0;
      if (ovr_set)        overrun   <= 1'b1;
      else if (clear_err) overrun   <= 1'b0;
    end
  end

  assign busy = (state == BS_SHIFT);

endmodule

// File: tb/tb_bs_deser.sv
// Randomized and directed bench for bs_deser: a word-level reference model feeds
// an expected-word queue that an independent monitor drains on each handshake.
module tb_bs_deser;

  localparam int LEN = 22;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           is = 1'b0;
  logic           isync = 1'b0;
  logic [LEN-1:0] o_data;
  logic           o_valid;
  logic           o_ready = 1'b0;
  logic           busy;
  logic           frame_err;
  logic           overrun;
  logic           clear_err = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state.
  logic           bitq[$];
  logic [LEN-1:0] mbuf[$];
  logic [LEN-1:0] exp_q[$];
  logic           m_ferr = 1'b0;
  logic           m_ovr = 1'b0;

  always #5 clk = ~clk;

  bs_deser #(.LEN(LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .is        (is),
    .isync     (isync),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clear_err (clear_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // Predicts the effect of the coming clock edge from the current inputs.
  task automatic model_edge();
    logic           done;
    logic           pop;
    logic [LEN-1:0] w;
    done = 1'b0;
    w    = '0;
    if (isync) begin
      if (bitq.size() > 0) m_ferr = 1'b1;
      else if (clear_err)  m_ferr = 1'b0;
      bitq.delete();
      bitq.push_back(is);
    end else begin
      if (clear_err) m_ferr = 1'b0;
      if (bitq.size() > 0) begin
        bitq.push_back(is);
        if (bitq.size() == LEN) begin
          done = 1'b1;
          for (int i = 0; i < LEN; i++) w[i] = bitq[i];
          bitq.delete();
        end
      end
    end
    pop = (mbuf.size() > 0) && o_ready;
    if (pop) void'(mbuf.pop_front());
    if (done && mbuf.size() < 2) begin
      mbuf.push_back(w);
      exp_q.push_back(w);
      if (clear_err) m_ovr = 1'b0;
    end else if (done) begin
      m_ovr = 1'b1;
    end else if (clear_err) begin
      m_ovr = 1'b0;
    end
  endtask

  task automatic check_state();
    chk("o_valid", 32'(o_valid), 32'(mbuf.size() > 0));
    chk("busy", 32'(busy), 32'(bitq.size() > 0));
    chk("frame_err", 32'(frame_err), 32'(m_ferr));
    chk("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic step(input logic b, input logic s, input logic rdy, input logic clr);
    @(posedge clk);
    #1;
    check_state();
    is        = b;
    isync     = s;
    o_ready   = rdy;
    clear_err = clr;
    model_edge();
  endtask

  task automatic send_word(input logic [LEN-1:0] w, input logic rdy);
    for (int i = 0; i < LEN; i++) step(w[i], i == 0, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    check_state();
    reset = 1'b0;
    is = 1'b0; isync = 1'b0; o_ready = 1'b0; clear_err = 1'b0;
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    bitq.delete(); mbuf.delete(); exp_q.delete();
    m_ferr = 1'b0; m_ovr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_edge();
  endtask

  // Monitor: every presented word must be the oldest expected one.
  always @(negedge clk) begin
    if (reset && o_valid) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL o_data: got 0x%0h, expected no word at %0t", o_data, $time);
      end else begin
        chk("o_data", 32'(o_data), 32'(exp_q[0]));
        if (o_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #12;
    chk("rst_hold_valid", 32'(o_valid), 32'd0);
    chk("rst_hold_data", 32'(o_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_edge();

    // Single frame with consumer ready.
    send_word(22'h012345, 1'b1);
    idle(4, 1'b1);

    // Back-to-back frames into a stalled consumer; third word overruns.
    send_word(22'h3FFFFF, 1'b0);
    send_word(22'h000001, 1'b0);
    send_word(22'h2AAAAA, 1'b0);
    idle(3, 1'b0);
    idle(4, 1'b1);

    // Early sync at bit 10, then a complete frame.
    for (int i = 0; i < 10; i++) step(22'h155555 >> i, i == 0, 1'b1, 1'b0);
    send_word(22'h0ABCDE, 1'b1);
    idle(3, 1'b1);

    // Both flags set: clear them, then clear coinciding with an early isync.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i < LEN; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);

    // Full buffer with push and pop in the same cycle.
    send_word(22'h111111, 1'b0);
    send_word(22'h222222, 1'b0);
    for (int i = 0; i < LEN; i++) step(22'h333333 >> i, i == 0, i == LEN - 1, 1'b0);
    idle(2, 1'b0);
    idle(4, 1'b1);

    // Reset mid-frame with one word buffered, then a clean frame.
    send_word(22'h05A5A5, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, i == 0, 1'b0, 1'b0);
    do_reset();
    send_word(22'h0F0F0F, 1'b1);
    idle(3, 1'b1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      logic s;
      if (bitq.size() == 0) s = ($urandom_range(0, 2) == 0);
      else                  s = ($urandom_range(0, 59) == 0);
      step(1'($urandom), s, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
    end

    idle(LEN + 6, 1'b1);
    @(negedge clk);
    chk("drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bs_deser.md
Name: bs_deser

Overview:
- Bit-serial-to-parallel receiver at the output end of the bit-serial arithmetic chain, e.g. the modular multiplier.
- Takes one LSB-first serial word per frame, framed by a sync pulse, and assembles it into a LEN-bit parallel word.
- Presents the word on a valid/ready output through a 2-entry buffer, so a slow consumer does not stall the free-running serial pipeline.
- Framing errors and overruns are reported on sticky flags.

Parameters:
- LEN, 22, serial word length in bits; also the o_data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- is  input  1  serial data bit, LSB first.
- isync  input  1  frame start; high in the cycle that carries bit 0.
- o_data  output  LEN  assembled word, head of buffer.
- o_valid  output  1  buffer non-empty.
- o_ready  input  1  consumer accepts o_data when o_valid && o_ready.
- busy  output  1  frame assembly in progress (state SHIFT).
- frame_err  output  1  sticky: a frame was aborted by an early isync.
- overrun  output  1  sticky: a completed word was dropped because the buffer was full.
- clear_err  input  1  synchronous clear of frame_err and overrun.

Behaviour:
- Reset (reset=0, asynchronous), held until release:
  - state IDLE, bit counter 0, shift register 0, buffer empty.
  - o_valid=0, o_data=0, busy=0, frame_err=0, overrun=0.
- FSM states are IDLE and SHIFT.
  - IDLE: is is ignored while isync=0. When isync=1, bit 0 is captured into shift[0], count=1, go to SHIFT.
  - SHIFT, isync=0: capture is into shift[count], count++. When the captured bit is bit LEN-1, push the word and go to IDLE with count=0.
  - SHIFT, isync=1 with count<LEN: discard the partial word and set frame_err. The current bit is bit 0 of a new frame; count=1, stay in SHIFT.
  - Back-to-back frames: isync in the cycle right after bit LEN-1 is legal. It is handled as the IDLE case, with no error and no gap cycle.
- Latency: the word is visible on o_data with o_valid=1 in the cycle after bit LEN-1 is sampled, provided the buffer was empty.
- Bits are placed by index, not shifted, so o_data[i] = serial bit i.
- Output buffer: 2-entry FIFO, head on o_data.
  - Pop when o_valid && o_ready.
  - o_data and o_valid stay stable while o_valid=1 and o_ready=0.
  - Push into a full buffer with no pop in the same cycle: the new word is dropped, overrun is set, and buffer contents are unchanged.
  - Push and pop in the same cycle:
    - When full, the push is accepted and overrun stays unchanged.
    - When holding 1 entry, the count stays at 1 and the pushed word becomes the head next cycle.
  - Push into an empty buffer with o_ready=1: the word appears the next cycle and pops in that cycle. There is no combinational bypass from is to o_data.
- Sticky flags:
  - Set only by their own events; cleared only by clear_err or reset.
  - If clear_err and a set event occur in the same cycle, set wins.
- busy = (state==SHIFT).
- Reset mid-frame drops both the partial word and the buffered words. After release, the next isync starts cleanly.
- All outputs are registered.

Decomposition:
- Shared package bs_pkg holds:
  - state encoding (BS_IDLE, BS_SHIFT);
  - default word length BS_LEN=22;
  - the counter width function, clog2(LEN+1).
- One natural sub-module: bs_fifo2 (2-entry valid/ready buffer, LEN-bit data).
  - Ports: push, push_data, full, pop, head, valid.
  - The overrun decision stays in bs_deser.
  - bs_fifo2 is reusable by a future parallel-to-serial front end.

Test Plan (LEN=22):
- Single frame: send 0x012345 LSB-first, isync with bit 0, o_ready=1.
  -> o_valid=1 for one cycle, o_data=0x012345, 22 cycles after the isync cycle. busy is high for cycles 1..21. frame_err=0, overrun=0.
- Back-to-back frames 0x3FFFFF, 0x000001, 0x2AAAAA with o_ready=0 throughout:
  -> first two words held, o_data=0x3FFFFF stable. Third word dropped, overrun=1.
  -> Then raise o_ready: pops 0x3FFFFF, then 0x000001, then o_valid=0.
- Early sync: start frame 0x155555, assert isync again at bit 10, then send the full frame 0x0ABCDE.
  -> frame_err=1 from the cycle after the early isync. Only 0x0ABCDE is delivered.
- Full buffer with push and pop in the same cycle: fill with 0x111111 and 0x222222, pulse o_ready in the cycle 0x333333 completes.
  -> overrun stays 0. Subsequent pops give 0x222222, then 0x333333.
- Reset mid-frame: assert reset at bit 12 of a frame while 1 word is buffered.
  -> all outputs 0 immediately. After release, frame 0x0F0F0F is received correctly.
- Flag clear: with both flags set, pulse clear_err -> both 0 next cycle. clear_err coinciding with a new early isync -> frame_err remains 1.
